dino_game_ctrl: RTL

Per-frame game controller for the dino runner, sitting directly upstream of the sprite/score renderer. Once per video frame it advances jump/duck physics and the score digit. It then drives the renderer's register-write port (chipselect/write/address/writedata) with a fixed two-word update sequence: dino Y, then score. It also exports pose and game-over status for software and LEDs.

---
 rtl/dino_game_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: per-frame dino runner controller.
// Once per video frame it advances the jump/duck physics and the score digit.
// It then writes dino Y (reg 1) and score (reg 10) to the renderer register port.
// Optional feature macro: DINO_CTRL_DUCK_EN enables the DUCK pose and duck_btn.
module dino_game_ctrl #(
  parameter int unsigned GROUND_Y  = 100,
  parameter int unsigned JUMP_V0   = 12,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned DUCK_DROP = 8,
  parameter int unsigned SCORE_DIV = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        jump_btn,
  input  logic        duck_btn,
  input  logic        collision,
  output logic        wr_chipselect,
  output logic        wr_write,
  output logic [8:0]  wr_address,
  output logic [31:0] wr_writedata,
  output logic [7:0]  dino_y,
  output logic [3:0]  score,
  output logic [1:0]  pose,
  output logic        game_over
);

  localparam int unsigned DIV_W     = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int unsigned Y_W       = 8;
  localparam int unsigned NXT_W     = 10;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 32;
  localparam logic [ADDR_W-1:0] ADDR_Y     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_SCORE = ADDR_W'(10);

  // Encoding doubles as the exported pose value.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_JUMP = 2'd1,
    ST_DUCK = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_W0   = 2'd1,
    SEQ_W1   = 2'd2
  } seq_state_e;

  game_state_e             r_state, w_state_nxt;
  logic [Y_W-1:0]          r_y, w_y_nxt;
  logic signed [Y_W-1:0]   r_vel, w_vel_nxt;
  logic [3:0]              r_score, w_score_nxt;
  logic [DIV_W-1:0]        r_div, w_div_nxt;
  logic                    r_pending, w_pending_nxt;
  logic                    r_jump_q;
  logic                    r_game_over;

  seq_state_e              r_seq, w_seq_nxt;
  logic                    r_cs, w_cs_nxt;
  logic                    r_wr, w_wr_nxt;
  logic [ADDR_W-1:0]       r_addr, w_addr_nxt;
  logic [DATA_W-1:0]       r_data, w_data_nxt;

  logic                    w_rise;
  logic                    w_jump_step;
  logic signed [Y_W-1:0]   w_step_vel;
  logic signed [NXT_W-1:0] w_nxt;
  logic                    w_duck_req;

  assign w_rise      = jump_btn & ~r_jump_q;
  // A jump taken from RUN starts from JUMP_V0 and steps in the same frame.
  assign w_jump_step = (r_state == ST_JUMP) || ((r_state == ST_RUN) && r_pending);
  assign w_step_vel  = (r_state == ST_RUN) ? $signed(Y_W'(JUMP_V0)) : r_vel;
  assign w_nxt       = $signed({2'b00, r_y}) - $signed({{2{w_step_vel[Y_W-1]}}, w_step_vel});

`ifdef DINO_CTRL_DUCK_EN
  assign w_duck_req = duck_btn;
`else
  logic w_unused_duck;
  assign w_unused_duck = duck_btn ^ (DUCK_DROP == 32'd0);
  assign w_duck_req    = 1'b0;
`endif

  assign dino_y        = r_y;
  assign score         = r_score;
  assign pose          = 2'(r_state);
  assign game_over     = r_game_over;
  assign wr_chipselect = r_cs;
  assign wr_write      = r_wr;
  assign wr_address    = r_addr;
  assign wr_writedata  = r_data;

  // Game state, physics, score divider and pending-jump latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_y_nxt       = r_y;
    w_vel_nxt     = r_vel;
    w_score_nxt   = r_score;
    w_div_nxt     = r_div;
    w_pending_nxt = r_pending | w_rise;

    if (r_state == ST_OVER) begin
      w_pending_nxt = 1'b0;
      if (w_rise && !collision) begin
        w_state_nxt = ST_RUN;
        w_y_nxt     = Y_W'(GROUND_Y);
        w_vel_nxt   = '0;
        w_score_nxt = 4'd0;
        w_div_nxt   = '0;
      end
    end else if (collision) begin
      w_state_nxt   = ST_OVER;
      w_pending_nxt = 1'b0;
    end else if (frame_start) begin
      if (r_div == DIV_W'(SCORE_DIV - 1)) begin
        w_div_nxt   = '0;
        w_score_nxt = (r_score == 4'd9) ? 4'd0 : r_score + 4'd1;
      end else begin
        w_div_nxt = r_div + DIV_W'(1);
      end

      if (w_jump_step) begin
        w_pending_nxt = (r_state == ST_RUN) ? 1'b0 : w_pending_nxt;
        w_state_nxt   = ST_JUMP;
        w_vel_nxt     = w_step_vel - $signed(Y_W'(GRAVITY));
        if (w_nxt >= $signed(NXT_W'(GROUND_Y))) begin
          w_y_nxt     = Y_W'(GROUND_Y);
          w_state_nxt = ST_RUN;
        end else if (w_nxt[NXT_W-1]) begin
          w_y_nxt = '0;
        end else begin
          w_y_nxt = w_nxt[Y_W-1:0];
        end
      end else if ((r_state == ST_RUN) && w_duck_req) begin
`ifdef DINO_CTRL_DUCK_EN
        w_state_nxt = ST_DUCK;
        w_y_nxt     = Y_W'(GROUND_Y + DUCK_DROP);
`endif
      end else if ((r_state == ST_DUCK) && !w_duck_req) begin
        w_state_nxt = ST_RUN;
        w_y_nxt     = Y_W'(GROUND_Y);
      end
    end
  end

  // Game registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_y         <= Y_W'(GROUND_Y);
      r_vel       <= '0;
      r_score     <= 4'd0;
      r_div       <= '0;
      r_pending   <= 1'b0;
      r_jump_q    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_y         <= w_y_nxt;
      r_vel       <= w_vel_nxt;
      r_score     <= w_score_nxt;
      r_div       <= w_div_nxt;
      r_pending   <= w_pending_nxt;
      r_jump_q    <= jump_btn;
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  // Two-word write sequencer; a new frame_start restarts at word 0 with fresh values.
  always_comb begin
    w_seq_nxt  = SEQ_IDLE;
    w_cs_nxt   = 1'b0;
    w_wr_nxt   = 1'b0;
    w_addr_nxt = '0;
    w_data_nxt = '0;
    if (frame_start) begin
      w_seq_nxt  = SEQ_W0;
      w_cs_nxt   = 1'b1;
      w_wr_nxt   = 1'b1;
      w_addr_nxt = ADDR_Y;
      w_data_nxt = {24'b0, w_y_nxt};
    end else if (r_seq == SEQ_W0) begin
      w_seq_nxt  = SEQ_W1;
      w_cs_nxt   = 1'b1;
      w_wr_nxt   = 1'b1;
      w_addr_nxt = ADDR_SCORE;
      w_data_nxt = {28'b0, r_score};
    end
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seq  <= SEQ_IDLE;
      r_cs   <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_seq  <= w_seq_nxt;
      r_cs   <= w_cs_nxt;
      r_wr   <= w_wr_nxt;
      r_addr <= w_addr_nxt;
      r_data <= w_data_nxt;
    end
  end

endmodule
